// File: rtl/decode_seq.sv
// decode_seq: instruction fetch/decode sequencer with a call-depth tracker.
// Instructions are fetched one word at a time (plus an optional immediate
// word). Each one is executed in a single EXEC cycle. Program flow is then
// redirected, or the sequencer stops in HALT.
module decode_seq #(
  parameter int              DW       = 16,
  parameter int              DEPTH    = 8,
  parameter logic [DW-1:0]   RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DW-1:0]                fetch_data,
  input  logic                         fetch_valid,
  input  logic                         cond_pass,
  input  logic [DW-1:0]                rd_data,
  input  logic                         resume,
  output logic                         fetch_req,
  output logic [DW-1:0]                fetch_addr,
  output logic [DW-1:0]                pc,
  output logic                         rd_wen,
  output logic [2:0]                   alu_sel,
  output logic [DW-1:0]                imm_out,
  output logic                         stack_push,
  output logic                         stack_pop,
  output logic [DW-1:0]                ret_addr,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         halted,
  output logic [1:0]                   fault
);

  localparam int DPW = $clog2(DEPTH+1);

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_CALL = 5'b00001;
  localparam logic [4:0] OP_CMPR = 5'b00010;
  localparam logic [4:0] OP_CMPI = 5'b00011;
  localparam logic [4:0] OP_JMPR = 5'b00100;
  localparam logic [4:0] OP_JMPI = 5'b00101;
  localparam logic [4:0] OP_ADDR = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01001;
  localparam logic [4:0] OP_RTN  = 5'b11100;
  localparam logic [4:0] OP_STP  = 5'b11111;

  localparam logic [DPW-1:0] DEPTH_MAX = DPW'(DEPTH);
  localparam logic [DW-1:0]  PC_ONE    = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {FETCH, IMM, EXEC, HALT} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   imm_q, imm_d;
  logic [DPW-1:0]  depth_q, depth_d;
  logic [1:0]      fault_q, fault_d;
  // Only the opcode field and the CMP skip count of the instruction word are
  // ever used, so the middle bits of the instruction register are not kept.
  logic [4:0]      opc_q, opc_d;
  logic [1:0]      skip_q, skip_d;

  // Opcodes that carry a second (immediate) word.
  function automatic logic needs_imm(input logic [4:0] opc);
    return (opc == OP_CALL) || (opc == OP_JMPI) ||
           (opc == OP_CMPI) || (opc == OP_ADDI);
  endfunction

  // State register; reset returns to a clean fetch at RESET_PC from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      imm_q   <= '0;
      depth_q <= '0;
      fault_q <= 2'b00;
      opc_q   <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
      opc_q   <= opc_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state logic and the one-cycle control pulses issued in EXEC.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    depth_d    = depth_q;
    fault_d    = fault_q;
    opc_d      = opc_q;
    skip_d     = skip_q;
    fetch_req  = 1'b0;
    rd_wen     = 1'b0;
    alu_sel    = 3'b000;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    ret_addr   = '0;

    case (state_q)
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_valid) begin
          opc_d   = fetch_data[15:11];
          skip_d  = fetch_data[1:0];
          pc_d    = pc_q + PC_ONE;
          state_d = needs_imm(fetch_data[15:11]) ? IMM : EXEC;
        end
      end

      IMM: begin
        fetch_req = 1'b1;
        if (fetch_valid) begin
          imm_d   = fetch_data;
          pc_d    = pc_q + PC_ONE;
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = FETCH;
        case (opc_q)
          OP_NOP: ;
          OP_ADDR, OP_ADDI: begin
            rd_wen  = 1'b1;
            alu_sel = 3'b100;
          end
          OP_CMPR, OP_CMPI: begin
            if (cond_pass)
              pc_d = pc_q + {{(DW-2){1'b0}}, skip_q} + PC_ONE;
          end
          OP_JMPR: pc_d = rd_data;
          OP_JMPI: pc_d = imm_q;
          OP_CALL: begin
            if (depth_q < DEPTH_MAX) begin
              stack_push = 1'b1;
              rd_wen     = 1'b1;
              alu_sel    = 3'b001;
              ret_addr   = pc_q;
              pc_d       = imm_q;
              depth_d    = depth_q + DPW'(1);
            end else begin
              fault_d = 2'b01;
              state_d = HALT;
            end
          end
          OP_RTN: begin
            if (depth_q != '0) begin
              stack_pop = 1'b1;
              pc_d      = rd_data;
              depth_d   = depth_q - DPW'(1);
            end else begin
              fault_d = 2'b10;
              state_d = HALT;
            end
          end
          OP_STP: state_d = HALT;
          default: begin
            fault_d = 2'b11;
            state_d = HALT;
          end
        endcase
      end

      HALT: begin
        if (resume && (fault_q == 2'b00))
          state_d = FETCH;
      end

      default: state_d = FETCH;
    endcase
  end

  assign fetch_addr = pc_q;
  assign pc         = pc_q;
  assign imm_out    = imm_q;
  assign depth      = depth_q;
  assign fault      = fault_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_decode_seq.sv
// tb_decode_seq: scoreboard bench for decode_seq. An instruction-level model
// walks each program ahead of time, filling program memory and queueing the
// expected fetch addresses and EXEC pulses; a responder acts as memory and a
// monitor compares whatever the DUT presents.
module tb_decode_seq;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int DPW   = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DW-1:0]   fetch_data = '0;
  logic            fetch_valid = 1'b0;
  logic            cond_pass = 1'b0;
  logic [DW-1:0]   rd_data = '0;
  logic            resume;
  logic            resumeMain = 1'b0;
  logic            resumeRnd = 1'b0;
  logic            fetch_req;
  logic [DW-1:0]   fetch_addr;
  logic [DW-1:0]   pc;
  logic            rd_wen;
  logic [2:0]      alu_sel;
  logic [DW-1:0]   imm_out;
  logic            stack_push;
  logic            stack_pop;
  logic [DW-1:0]   ret_addr;
  logic [DPW-1:0]  depth;
  logic            halted;
  logic [1:0]      fault;

  assign resume = resumeMain | resumeRnd;

  decode_seq #(.DW(DW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .cond_pass(cond_pass), .rd_data(rd_data), .resume(resume),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .pc(pc), .rd_wen(rd_wen),
    .alu_sel(alu_sel), .imm_out(imm_out), .stack_push(stack_push),
    .stack_pop(stack_pop), .ret_addr(ret_addr), .depth(depth),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdWen;
    logic [2:0]  alu;
    logic        push;
    logic        pop;
    logic [15:0] ret;
    int          depthBefore;
  } exec_t;

  typedef struct {
    logic        cond;
    logic [15:0] rd;
  } execIn_t;

  logic [15:0]  mem [int];
  int unsigned  expFetch [$];
  exec_t        expExec [$];
  execIn_t      execIn [$];

  logic [15:0]  finPc;
  int           finDepth;
  logic         finHalt;
  logic [1:0]   finFault;

  int testsRun = 0;
  int testsFailed = 0;
  int validPct = 100;
  int forceCond = -1;
  bit rndResumeEn = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Random instruction word, weighted so nesting, returns and halts all occur.
  function automatic logic [15:0] genInstr();
    int r;
    logic [4:0] opc;
    logic [4:0] plain [6];
    logic [4:0] bad [5];
    plain = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9};
    bad   = '{5'd6, 5'd7, 5'd10, 5'd16, 5'd30};
    r = $urandom_range(99);
    if (r < 2)       opc = bad[$urandom_range(4)];
    else if (r < 5)  opc = 5'd31;
    else if (r < 28) opc = 5'd1;
    else if (r < 40) opc = 5'd28;
    else if (r < 48) opc = 5'd5;
    else             opc = plain[$urandom_range(5)];
    return {opc, 11'($urandom)};
  endfunction

  function automatic logic [15:0] fetchWord(input logic [15:0] addr, input bit isOp);
    if (!mem.exists(int'(addr)))
      mem[int'(addr)] = isOp ? genInstr() : 16'($urandom);
    return mem[int'(addr)];
  endfunction

  // Instruction-level reference: runs the program from address 0 with a real
  // return-address stack and records what every fetch and EXEC should show.
  task automatic applyStimulus(input int maxInstr);
    logic [15:0] p, word, imm, rd;
    logic [4:0]  opc;
    logic        c;
    logic [15:0] stk [$];
    exec_t       rec;
    execIn_t     ei;
    bit          done;
    logic [1:0]  flt;
    p = '0; done = 1'b0; flt = 2'b00;
    for (int n = 0; n < maxInstr && !done; n++) begin
      word = fetchWord(p, 1'b1);
      expFetch.push_back(int'(p));
      p = p + 16'd1;
      opc = word[15:11];
      imm = '0;
      if (opc == 5'd1 || opc == 5'd3 || opc == 5'd5 || opc == 5'd9) begin
        imm = fetchWord(p, 1'b0);
        expFetch.push_back(int'(p));
        p = p + 16'd1;
      end
      c  = (forceCond >= 0) ? forceCond[0] : 1'($urandom_range(1));
      rd = 16'($urandom);
      rec.rdWen = 1'b0; rec.alu = 3'd0; rec.push = 1'b0; rec.pop = 1'b0;
      rec.ret = '0; rec.depthBefore = stk.size();
      case (opc)
        5'd0: ;
        5'd8, 5'd9: begin rec.rdWen = 1'b1; rec.alu = 3'd4; end
        5'd2, 5'd3: if (c) p = p + 16'(word[1:0]) + 16'd1;
        5'd4: p = rd;
        5'd5: p = imm;
        5'd1: begin
          if (stk.size() < DEPTH) begin
            rec.push = 1'b1; rec.rdWen = 1'b1; rec.alu = 3'd1; rec.ret = p;
            stk.push_back(p);
            p = imm;
          end else begin
            flt = 2'b01; done = 1'b1;
          end
        end
        5'd28: begin
          if (stk.size() > 0) begin
            rec.pop = 1'b1;
            rd = stk.pop_back();
            p = rd;
          end else begin
            flt = 2'b10; done = 1'b1;
          end
        end
        5'd31: done = 1'b1;
        default: begin flt = 2'b11; done = 1'b1; end
      endcase
      ei.cond = c; ei.rd = rd;
      expExec.push_back(rec);
      execIn.push_back(ei);
    end
    finPc = p; finDepth = stk.size(); finHalt = done; finFault = flt;
  endtask

  // Memory responder plus EXEC-time operand driver, all just after the edge.
  always begin
    execIn_t ei;
    @(posedge clk);
    #1;
    if (fetch_req)
      fetch_valid = (expFetch.size() > 0) && ($urandom_range(99) < validPct);
    else
      fetch_valid = ($urandom_range(3) == 0);
    fetch_data = (fetch_req && mem.exists(int'(fetch_addr))) ? mem[int'(fetch_addr)] : 16'($urandom);
    if (!reset && !fetch_req && !halted && execIn.size() > 0) begin
      ei = execIn.pop_front();
      cond_pass = ei.cond;
      rd_data = ei.rd;
    end else begin
      cond_pass = 1'($urandom);
      rd_data = 16'($urandom);
    end
    resumeRnd = (rndResumeEn && !halted) ? 1'($urandom_range(1)) : 1'b0;
  end

  // Monitor: fetch handshakes and EXEC cycles are popped and compared.
  always @(negedge clk) begin
    exec_t rec;
    int unsigned a;
    if (!reset) begin
      if (fetch_req && fetch_valid && expFetch.size() > 0) begin
        a = expFetch.pop_front();
        checkOutput("fetchAddr", 32'(fetch_addr), a);
      end
      if (!fetch_req && !halted) begin
        if (expExec.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpectedExec: got EXEC cycle at pc 0x%0h, expected none", pc);
        end else begin
          rec = expExec.pop_front();
          checkOutput("execDepth", 32'(depth), rec.depthBefore);
          checkOutput("rdWen", 32'(rd_wen), 32'(rec.rdWen));
          checkOutput("aluSel", 32'(alu_sel), 32'(rec.alu));
          checkOutput("stackPush", 32'(stack_push), 32'(rec.push));
          checkOutput("stackPop", 32'(stack_pop), 32'(rec.pop));
          if (rec.push) checkOutput("retAddr", 32'(ret_addr), 32'(rec.ret));
        end
      end
    end
  end

  // Assert reset (possibly mid-cycle) and check that everything clears at once.
  task automatic doReset();
    reset = 1'b1;
    #1;
    checkOutput("rstPc", 32'(pc), 32'h0);
    checkOutput("rstFetchReq", 32'(fetch_req), 32'h1);
    checkOutput("rstFetchAddr", 32'(fetch_addr), 32'h0);
    checkOutput("rstDepth", 32'(depth), 32'h0);
    checkOutput("rstFault", 32'(fault), 32'h0);
    checkOutput("rstHalted", 32'(halted), 32'h0);
    checkOutput("rstImm", 32'(imm_out), 32'h0);
    checkOutput("rstPulses", {28'h0, rd_wen, stack_push, stack_pop, |alu_sel}, 32'h0);
    expFetch.delete();
    expExec.delete();
    execIn.delete();
    mem.delete();
    forceCond = -1;
  endtask

  task automatic releaseReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait for the model's expectations to drain, then check final state and
  // how the sequencer reacts to resume.
  task automatic waitDone();
    int cnt = 0;
    while ((expFetch.size() > 0 || expExec.size() > 0) && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 3000) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL timeout: got %0d fetches and %0d execs pending, expected 0", expFetch.size(), expExec.size());
    end
    @(negedge clk);
    checkOutput("finalPc", 32'(pc), 32'(finPc));
    checkOutput("finalDepth", 32'(depth), finDepth);
    checkOutput("finalHalted", 32'(halted), 32'(finHalt));
    if (finHalt) begin
      checkOutput("finalFault", 32'(fault), 32'(finFault));
      resumeMain = 1'b1;
      @(negedge clk);
      resumeMain = 1'b0;
      if (finFault == 2'b00) begin
        checkOutput("resumeHalted", 32'(halted), 32'h0);
        checkOutput("resumeFetch", {fetch_req, 15'h0, fetch_addr}, {1'b1, 15'h0, finPc});
      end else begin
        checkOutput("faultStaysHalted", 32'(halted), 32'h1);
        checkOutput("faultStaysPc", 32'(pc), 32'(finPc));
      end
    end
  endtask

  initial begin
    int cyc;
    int cnt;

    // NOP, NOP, STP back to back: halts six cycles after reset release.
    @(negedge clk);
    doReset();
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'hF800;
    validPct = 100;
    applyStimulus(10);
    releaseReset();
    cyc = 0;
    while (!halted && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("haltCycle", cyc, 6);
    waitDone();

    // CMP I with skip 3 at address 4, both condition outcomes.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      doReset();
      for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
      mem[4] = 16'h1803; mem[5] = 16'h0005;
      mem[6] = 16'hF800; mem[10] = 16'hF800;
      forceCond = 1 - k;
      applyStimulus(10);
      checkOutput("cmpModelPc", 32'(finPc), (k == 0) ? 32'd11 : 32'd7);
      releaseReset();
      waitDone();
    end

    // CALL to 0x40 from 0x10, RTN back to 0x12, then STP.
    @(negedge clk);
    doReset();
    mem[0] = 16'h2800; mem[1] = 16'h0010;
    mem[16'h10] = 16'h0800; mem[16'h11] = 16'h0040;
    mem[16'h40] = 16'hE000; mem[16'h12] = 16'hF800;
    validPct = 70;
    applyStimulus(10);
    releaseReset();
    waitDone();

    // DEPTH+1 nested CALLs: the last one overflows and only reset recovers.
    @(negedge clk);
    doReset();
    for (int i = 0; i <= DEPTH; i++) begin
      mem[2*i] = 16'h0800;
      mem[2*i+1] = 16'(2*i + 2);
    end
    applyStimulus(20);
    releaseReset();
    waitDone();

    // RTN at depth 0 underflows; opcode 00110 is illegal.
    @(negedge clk);
    doReset();
    mem[0] = 16'hE000;
    applyStimulus(5);
    releaseReset();
    waitDone();
    @(negedge clk);
    doReset();
    mem[0] = 16'h3000;
    applyStimulus(5);
    releaseReset();
    waitDone();

    // JMP I to 0xFFFF then NOP: the PC wraps to 0.
    @(negedge clk);
    doReset();
    mem[0] = 16'h2800; mem[1] = 16'hFFFF; mem[16'hFFFF] = 16'h0000;
    applyStimulus(4);
    releaseReset();
    waitDone();

    // Reset arriving mid-cycle while stalled in IMM.
    @(negedge clk);
    doReset();
    mem[0] = 16'h2800; mem[1] = 16'h1234;
    validPct = 100;
    expFetch.push_back(0);
    releaseReset();
    cnt = 0;
    while (!(fetch_req && fetch_addr == 16'd1) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("stallInImm", {fetch_req, 15'h0, fetch_addr}, {1'b1, 15'h0, 16'd1});
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    doReset();
    repeat (3) @(negedge clk);

    // Randomized programs with random fetch stalls.
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      doReset();
      validPct = 40 + $urandom_range(60);
      applyStimulus(40);
      releaseReset();
      waitDone();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/decode_seq.md
DECODE_SEQ -- requirements
Module: decode_seq

Interface
REQ-001 Parameter DW, default 16, data/address width; DW SHALL be >= 16.
REQ-002 Parameter DEPTH, default 8, maximum CALL nesting depth.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 fetch_data  in  DW  fetched word; opcode word uses bits [15:0], immediate word uses all DW bits.
REQ-007 fetch_valid  in  1  fetch_data valid this cycle.
REQ-008 cond_pass  in  1  ALU condition result, sampled in EXEC.
REQ-009 rd_data  in  DW  register-file read of Rd (jump/return target).
REQ-010 resume  in  1  leave HALT after STP.
REQ-011 fetch_req  out  1  fetch request; fetch_addr  out  DW  fetch address.
REQ-012 pc  out  DW  current program counter.
REQ-013 rd_wen  out  1; alu_sel  out  3; imm_out  out  DW  captured immediate.
REQ-014 stack_push  out  1; stack_pop  out  1; ret_addr  out  DW  value pushed on CALL.
REQ-015 depth  out  $clog2(DEPTH+1)  current call depth.
REQ-016 halted  out  1; fault  out  2  (00 none, 01 overflow, 10 underflow, 11 illegal opcode).

Function
REQ-017 States SHALL be FETCH, IMM, EXEC, HALT; opc = ir[15:11].
REQ-018 FETCH: fetch_req=1, fetch_addr=pc; on fetch_valid capture ir, pc<=pc+1; next IMM if opc in {00001 CALL, 00101 JMP I, 00011 CMP I, 01001 ADD I}, else EXEC; no fetch_valid -> stay.
REQ-019 IMM: fetch_req=1, fetch_addr=pc; on fetch_valid imm_out<=fetch_data, pc<=pc+1, next EXEC; else stay.
REQ-020 EXEC lasts exactly one cycle; control outputs are 1-cycle pulses asserted only in EXEC; next FETCH unless stated.
REQ-021 NOP 00000: no outputs.
REQ-022 ADD R 01000 / ADD I 01001: rd_wen=1, alu_sel=100.
REQ-023 CMP 0001x: if cond_pass, pc<=pc+ir[1:0]+1 (skip 1..4 words); else pc unchanged.
REQ-024 JMP R 00100: pc<=rd_data; JMP I 00101: pc<=imm_out.
REQ-025 CALL 00001: if depth<DEPTH: stack_push=1, rd_wen=1, alu_sel=001, ret_addr=pc, pc<=imm_out, depth+1; else fault=01, next HALT, pc unchanged.
REQ-026 RTN 11100: if depth>0: stack_pop=1, pc<=rd_data, depth-1; else fault=10, next HALT.
REQ-027 STP 11111: next HALT, fault=00; any other opc: fault=11, next HALT.
REQ-028 HALT: fetch_req=0, halted=1, pc held; resume=1 with fault=00 -> FETCH; with fault!=00 only reset exits.
REQ-029 All PC arithmetic SHALL wrap modulo 2^DW (pc=2^DW-1 +1 -> 0).
REQ-030 resume outside HALT SHALL be ignored; fetch_valid outside FETCH/IMM SHALL be ignored.
REQ-031 Latency: non-immediate instruction 2 cycles, immediate 3 cycles, with fetch_valid present every fetch cycle.

Reset
REQ-032 reset asserted at any time, including mid-IMM or EXEC, SHALL immediately set state=FETCH, pc=RESET_PC, depth=0, fault=00, ir=0, imm_out=0, all pulse outputs 0, halted=0.
REQ-033 First fetch after reset release SHALL request address RESET_PC on the next rising edge.

Verification
REQ-034 Reset, program NOP,NOP,STP at 0..2, fetch_valid=1 -> fetch_addr 0,1,2; halted=1 on cycle 6; pc=3.
REQ-035 CMP I (0x1803) at 4, imm 0x0005, cond_pass=1 -> next fetch_addr=4+2+3+1=10; cond_pass=0 -> 6.
REQ-036 CALL imm 0x0040 at pc 0x10 -> stack_push pulse, ret_addr=0x12, pc=0x40, depth=1; then RTN with rd_data=0x12 -> stack_pop, pc=0x12, depth=0.
REQ-037 DEPTH+1 nested CALLs -> final CALL: no stack_push, fault=01, halted=1; resume has no effect; reset clears.
REQ-038 JMP I imm=0xFFFF (DW=16), then NOP at 0xFFFF -> pc wraps to 0x0000.
REQ-039 reset pulsed during IMM with fetch_valid low -> pc=RESET_PC, imm_out=0, no EXEC pulses issued.
